rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
Pointer and occupancy controller for the reorder buffer. It sits between Dispatch and the ROB storage array. It allocates ROB slots in program order to Dispatch and returns the slot index and the full status. It tracks completion per slot and sequences in-order retirement from the head. A flush returns it to the empty state.

Parameters:
DEPTH, 16, number of ROB entries; must be a power of two, at least 2
IDX_W, $clog2(DEPTH), width of a ROB index

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
alloc_valid  input  1  Dispatch requests one new ROB entry this cycle
alloc_ready  output  1  an entry can be allocated; equals !rob_full
rob_index  output  IDX_W  index given to the allocating instruction; equals the current tail
rob_full  output  1  occupancy == DEPTH
rob_empty  output  1  occupancy == 0
complete_valid  input  1  writeback marks an entry done
complete_index  input  IDX_W  entry being marked done
commit_valid  output  1  head entry is allocated and done
commit_index  output  IDX_W  current head
commit_ack  input  1  commit stage retires the head this cycle
flush  input  1  discard all entries (mispredict or exception)

Behaviour:
- State: head, tail (IDX_W each), count (IDX_W+1), alloc_v[DEPTH], done[DEPTH].
- Reset, applied on the clock edge while rst=1:
  - head=tail=count=0; all alloc_v and done bits cleared.
  - Resulting outputs: rob_index=0, commit_index=0, rob_full=0, alloc_ready=1, rob_empty=1, commit_valid=0.
  - rst asserted mid-operation discards all state in the same edge; inputs that cycle are ignored.
- All outputs are combinational from registered state only. There is no input-to-output path.
  - rob_full and alloc_ready use the registered count, so a same-cycle commit does not free a slot for a same-cycle alloc.
- Allocate fire = alloc_valid && alloc_ready.
  - Next edge: alloc_v[tail]=1, done[tail]=0, tail=tail+1 mod DEPTH.
  - Dispatch samples rob_index in the fire cycle.
- Complete:
  - If complete_valid && alloc_v[complete_index], then done[complete_index]=1 next edge.
  - A complete to an unallocated index is ignored.
  - Repeat completes are idempotent.
- commit_valid = !rob_empty && done[head].
  - A completion to the head becomes visible one cycle later (no bypass).
- Commit fire = commit_valid && commit_ack.
  - Next edge: alloc_v[head]=0, done[head]=0, head=head+1 mod DEPTH.
  - commit_ack while commit_valid=0 is ignored.
- count next = count + alloc_fire - commit_fire.
  - Alloc and commit firing in the same cycle leave count unchanged; both pointers advance.
- Wrap-around: pointers wrap naturally at DEPTH (power of two). Full versus empty is disambiguated by count, not by pointer equality.
- Complete and commit to the same index in the same cycle: commit wins; the entry is freed with done=0.
- Flush has highest priority over alloc, complete and commit in that cycle:
  - head=tail=count=0; all alloc_v and done cleared.
  - Any same-cycle fires are discarded.
  - The Dispatch handshake in that cycle is void even if alloc_ready was 1.
- Latency: alloc to visible in count is 1 cycle; complete to commit_valid is 1 cycle minimum; commit to slot reusable is 1 cycle.

Optional Feature:
- Macro ROB_OCCUPANCY_OUT_EN.
- When defined:
  - Adds output rob_count [IDX_W:0], equal to the registered count (reset 0, flush 0).
  - Adds output rob_almost_full, asserted when count >= DEPTH-2; Dispatch uses it for early throttling.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Fill from reset, DEPTH=16: 16 back-to-back alloc_valid cycles.
  - Required: rob_index runs 0..15; rob_full=1 and alloc_ready=0 after the 16th.
  - A 17th request is not accepted; tail stays 0.
- Out-of-order completion: allocate 0..3, complete 2, 1, 3.
  - Required: commit_valid stays 0.
  - Complete 0, then commit_valid=1 next cycle with commit_index=0.
  - With commit_ack held high, indices 0, 1, 2, 3 retire on consecutive cycles.
- Wrap, DEPTH=16: allocate 14, complete and commit 14, then allocate 4 more.
  - Required: rob_index sequence 14, 15, 0, 1; rob_empty=0; commit_index=14.
- Simultaneous alloc and commit with count=16:
  - Required: alloc is rejected that cycle and count becomes 15.
  - Next cycle alloc is accepted with rob_index equal to the old head, and count returns to 16.
- Flush with alloc_valid, complete_valid and commit_ack all high at count=5:
  - Required next cycle: count=0, rob_empty=1, rob_index=0, commit_valid=0, and no done bits set.
  - The same checks hold for rst asserted at count=5.
- Unallocated complete, and the optional macro:
  - complete_index=9 on an empty ROB is ignored: a later allocation of slot 9 shows commit_valid=0.
  - With ROB_OCCUPANCY_OUT_EN defined: rob_count tracks 0→14, and rob_almost_full rises at count 14.

Source files
------------

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer pointer and occupancy controller.
// Allocates slots in program order, tracks per-slot completion and
// sequences in-order retirement from the head.
// Optional build macro ROB_OCCUPANCY_OUT_EN adds the rob_count and
// rob_almost_full outputs.
module rob_alloc_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] rob_index,
  output logic             rob_full,
  output logic             rob_empty,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_index,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_index,
  input  logic             commit_ack,
  input  logic             flush
`ifdef ROB_OCCUPANCY_OUT_EN
  ,
  output logic [IDX_W:0]   rob_count,
  output logic             rob_almost_full
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] head, head_nxt;
  logic [IDX_W-1:0] tail, tail_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [DEPTH-1:0] alloc_v, alloc_v_nxt;
  logic [DEPTH-1:0] done, done_nxt;
  logic             alloc_fire;
  logic             commit_fire;

  // Status outputs come from registered state only
  always_comb begin
    rob_full     = (count == CNT_W'(DEPTH));
    rob_empty    = (count == '0);
    alloc_ready  = !rob_full;
    rob_index    = tail;
    commit_index = head;
    commit_valid = !rob_empty && done[head];
    alloc_fire   = alloc_valid && alloc_ready;
    commit_fire  = commit_valid && commit_ack;
  end

`ifdef ROB_OCCUPANCY_OUT_EN
  // Occupancy export for early Dispatch throttling
  always_comb begin
    rob_count       = count;
    rob_almost_full = (count >= CNT_W'(DEPTH - 2));
  end
`endif

  // Next-state: alloc, then complete, then commit (commit wins on a shared
  // index); flush overrides everything
  always_comb begin
    head_nxt    = head;
    tail_nxt    = tail;
    count_nxt   = count;
    alloc_v_nxt = alloc_v;
    done_nxt    = done;

    if (alloc_fire) begin
      alloc_v_nxt[tail] = 1'b1;
      done_nxt[tail]    = 1'b0;
      tail_nxt          = tail + IDX_W'(1);
    end

    if (complete_valid && alloc_v[complete_index]) begin
      done_nxt[complete_index] = 1'b1;
    end

    if (commit_fire) begin
      alloc_v_nxt[head] = 1'b0;
      done_nxt[head]    = 1'b0;
      head_nxt          = head + IDX_W'(1);
    end

    count_nxt = count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);

    if (flush) begin
      head_nxt    = '0;
      tail_nxt    = '0;
      count_nxt   = '0;
      alloc_v_nxt = '0;
      done_nxt    = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      alloc_v <= '0;
      done    <= '0;
    end else begin
      head    <= head_nxt;
      tail    <= tail_nxt;
      count   <= count_nxt;
      alloc_v <= alloc_v_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed self-checking bench for rob_alloc_ctrl (DEPTH=16).
module tb_rob_alloc_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] rob_index;
  logic             rob_full;
  logic             rob_empty;
  logic             complete_valid;
  logic [IDX_W-1:0] complete_index;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_index;
  logic             commit_ack;
  logic             flush;
`ifdef ROB_OCCUPANCY_OUT_EN
  logic [IDX_W:0]   rob_count;
  logic             rob_almost_full;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rob_alloc_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .rob_index      (rob_index),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .commit_valid   (commit_valid),
    .commit_index   (commit_index),
    .commit_ack     (commit_ack),
    .flush          (flush)
`ifdef ROB_OCCUPANCY_OUT_EN
    ,
    .rob_count      (rob_count),
    .rob_almost_full(rob_almost_full)
`endif
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid = 1'b1;
    repeat (n) step();
    alloc_valid = 1'b0;
  endtask

  task automatic complete_range(input int first, input int n);
    complete_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      complete_index = IDX_W'((first + i) % DEPTH);
      step();
    end
    complete_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; complete_valid = 1'b0;
    complete_index = '0; commit_ack = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;

    // Reset state
    check("rst_rob_index", 32'(rob_index), 0);
    check("rst_commit_index", 32'(commit_index), 0);
    check("rst_full", 32'(rob_full), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_empty", 32'(rob_empty), 1);
    check("rst_commit_valid", 32'(commit_valid), 0);

    // Fill from reset
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_idx%0d", i), 32'(rob_index), 32'(i));
      check($sformatf("fill_ready%0d", i), 32'(alloc_ready), 1);
      step();
    end
    check("fill_full", 32'(rob_full), 1);
    check("fill_ready_lo", 32'(alloc_ready), 0);
    step();   // 17th request held high
    alloc_valid = 1'b0;
    check("fill17_tail", 32'(rob_index), 0);
    check("fill17_full", 32'(rob_full), 1);
    check("fill17_nocommit", 32'(commit_valid), 0);

    // Out-of-order completion, in-order retirement
    do_reset();
    alloc_n(4);
    complete_valid = 1'b1;
    complete_index = 4'd2; step(); check("ooo_c2", 32'(commit_valid), 0);
    complete_index = 4'd1; step(); check("ooo_c1", 32'(commit_valid), 0);
    complete_index = 4'd3; step(); check("ooo_c3", 32'(commit_valid), 0);
    complete_index = 4'd0; step();
    complete_valid = 1'b0;
    check("ooo_c0_valid", 32'(commit_valid), 1);
    check("ooo_c0_index", 32'(commit_index), 0);
    commit_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ooo_ret_valid%0d", i), 32'(commit_valid), 1);
      check($sformatf("ooo_ret_idx%0d", i), 32'(commit_index), 32'(i));
      step();
    end
    commit_ack = 1'b0;
    check("ooo_empty", 32'(rob_empty), 1);
    check("ooo_noval", 32'(commit_valid), 0);

    // Wrap-around
    do_reset();
    alloc_n(14);
    complete_range(0, 14);
    commit_ack = 1'b1;
    repeat (14) step();
    commit_ack = 1'b0;
    check("wrap_empty_mid", 32'(rob_empty), 1);
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_idx%0d", i), 32'(rob_index), 32'((14 + i) % 16));
      step();
    end
    alloc_valid = 1'b0;
    check("wrap_empty", 32'(rob_empty), 0);
    check("wrap_commit_idx", 32'(commit_index), 14);

    // Simultaneous alloc and commit while full
    do_reset();
    alloc_n(16);
    complete_range(0, 1);
    check("sim_cv", 32'(commit_valid), 1);
    alloc_valid = 1'b1;
    commit_ack  = 1'b1;
    check("sim_ready_lo", 32'(alloc_ready), 0);
    step();
    commit_ack = 1'b0;
    check("sim_not_full", 32'(rob_full), 0);
    check("sim_ready", 32'(alloc_ready), 1);
    check("sim_idx_old_head", 32'(rob_index), 0);
    step();
    alloc_valid = 1'b0;
    check("sim_full_again", 32'(rob_full), 1);
    check("sim_head", 32'(commit_index), 1);
    check("sim_cv_after", 32'(commit_valid), 0);

    // Flush with every request high at count=5
    do_reset();
    alloc_n(5);
    complete_range(0, 1);
    alloc_valid = 1'b1; complete_valid = 1'b1; complete_index = 4'd1;
    commit_ack = 1'b1; flush = 1'b1;
    step();
    alloc_valid = 1'b0; complete_valid = 1'b0; commit_ack = 1'b0; flush = 1'b0;
    check("fl_empty", 32'(rob_empty), 1);
    check("fl_full", 32'(rob_full), 0);
    check("fl_idx", 32'(rob_index), 0);
    check("fl_head", 32'(commit_index), 0);
    check("fl_cv", 32'(commit_valid), 0);
    check("fl_done", 32'(dut.done), 0);
    check("fl_alloc_v", 32'(dut.alloc_v), 0);

    // Same requests with rst at count=5
    alloc_n(5);
    complete_range(0, 2);
    alloc_valid = 1'b1; complete_valid = 1'b1; complete_index = 4'd2;
    commit_ack = 1'b1; rst = 1'b1;
    step();
    alloc_valid = 1'b0; complete_valid = 1'b0; commit_ack = 1'b0; rst = 1'b0;
    check("rs_empty", 32'(rob_empty), 1);
    check("rs_idx", 32'(rob_index), 0);
    check("rs_cv", 32'(commit_valid), 0);
    check("rs_done", 32'(dut.done), 0);
    check("rs_alloc_v", 32'(dut.alloc_v), 0);

    // Complete to an unallocated slot is dropped
    do_reset();
    complete_valid = 1'b1; complete_index = 4'd9;
    step();
    complete_valid = 1'b0;
    check("ua_empty", 32'(rob_empty), 1);
    alloc_n(10);
    complete_range(0, 9);
    commit_ack = 1'b1;
    repeat (9) step();
    commit_ack = 1'b0;
    check("ua_head", 32'(commit_index), 9);
    check("ua_cv", 32'(commit_valid), 0);
    check("ua_empty_lo", 32'(rob_empty), 0);

`ifdef ROB_OCCUPANCY_OUT_EN
    // Occupancy outputs track 0..14
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("occ_cnt%0d", i), 32'(rob_count), 32'(i));
      check($sformatf("occ_af%0d", i), 32'(rob_almost_full), 0);
      step();
    end
    alloc_valid = 1'b0;
    check("occ_cnt14", 32'(rob_count), 14);
    check("occ_af14", 32'(rob_almost_full), 1);
    flush = 1'b1; step(); flush = 1'b0;
    check("occ_flush", 32'(rob_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
